// File: rtl/frame_trigger_matcher_pkg.sv
// rtl/frame_trigger_matcher_pkg.sv - shared types and constants for frame_trigger_matcher
package frame_trigger_matcher_pkg;

  localparam int FTM_DATA_W  = 32;
  localparam int FTM_STRB_W  = FTM_DATA_W / 8;
  localparam int FTM_COUNT_W = 16;

  typedef enum logic [2:0] {
    FTM_IDLE,
    FTM_COMPARE,
    FTM_TRIGGER,
    FTM_CAPTURE,
    FTM_SKIP
  } ftm_state_e;

  // Trigger count sticks at all-ones instead of wrapping back to zero
  function automatic logic [FTM_COUNT_W-1:0] sat_inc(input logic [FTM_COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/frame_trigger_matcher_if.sv
// rtl/frame_trigger_matcher_if.sv - receive-beat snoop bus for frame_trigger_matcher
interface frame_trigger_matcher_if;
  import frame_trigger_matcher_pkg::*;

  logic [FTM_DATA_W-1:0] RvviAxiRdata;
  logic [FTM_STRB_W-1:0] RvviAxiRstrb;
  logic                  RvviAxiRlast;
  logic                  RvviAxiRvalid;

  modport master (output RvviAxiRdata, output RvviAxiRstrb, output RvviAxiRlast, output RvviAxiRvalid);
  modport slave  (input  RvviAxiRdata, input  RvviAxiRstrb, input  RvviAxiRlast, input  RvviAxiRvalid);

endinterface

// File: rtl/trigger_pattern_cmp.sv
// rtl/trigger_pattern_cmp.sv - per-byte masked compare of one beat against one pattern word
module trigger_pattern_cmp
  import frame_trigger_matcher_pkg::*;
(
  input  logic [FTM_DATA_W-1:0] word_i,
  input  logic [FTM_DATA_W-1:0] mask_i,
  input  logic [FTM_STRB_W-1:0] strb_i,
  input  logic [FTM_DATA_W-1:0] data_i,
  output logic [FTM_STRB_W-1:0] byte_pass_o
);

  logic [FTM_DATA_W-1:0] diff;

  assign diff = (data_i ^ word_i) & mask_i;

  // A byte passes when its compared bits agree; a byte with any compared bit must also be strobed
  always_comb begin
    byte_pass_o = '0;
    for (int j = 0; j < FTM_STRB_W; j++) begin
      byte_pass_o[j] = (diff[j*8 +: 8] == 8'h00) && ((mask_i[j*8 +: 8] == 8'h00) || strb_i[j]);
    end
  end

endmodule

// File: rtl/frame_trigger_matcher.sv
// rtl/frame_trigger_matcher.sv - multi-pattern frame-start trigger with post-trigger message capture
module frame_trigger_matcher
  import frame_trigger_matcher_pkg::*;
#(
  parameter  int WORDS        = 5,
  parameter  int NUM_PATTERNS = 2,
  parameter  int TRIG_CYCLES  = 10,
  parameter  int MSG_WORDS    = 1,
  localparam int ID_W         = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
  localparam int PW           = NUM_PATTERNS * WORDS * FTM_DATA_W
) (
  input  logic                            clk,
  input  logic                            reset,
  frame_trigger_matcher_if.slave          rx,
  input  logic [PW-1:0]                   PatternString_i,
  input  logic [PW-1:0]                   PatternMask_i,
  input  logic [NUM_PATTERNS-1:0]         PatternEn_i,
  output logic                            IlaTrigger_o,
  output logic [ID_W-1:0]                 TriggerId_o,
  output logic [MSG_WORDS*FTM_DATA_W-1:0] TriggerMessage_o,
  output logic                            MessageValid_o,
  output logic [FTM_COUNT_W-1:0]          TriggerCount_o
);

  localparam int IDX_W  = $clog2(WORDS + 1);
  localparam int PC_W   = $clog2(TRIG_CYCLES + 1);
  localparam int SLOT_W = $clog2(MSG_WORDS + 1);

  ftm_state_e                      state_q, state_d;
  logic [IDX_W-1:0]                word_idx_q, word_idx_d;
  logic [NUM_PATTERNS-1:0]         alive_q, alive_d, alive_cur, word_pass;
  logic [PC_W-1:0]                 pulse_q, pulse_d;
  logic [SLOT_W-1:0]               slot_q, slot_d, cap_slot;
  logic                            last_q, last_d;
  logic [ID_W-1:0]                 id_q, id_d;
  logic [FTM_COUNT_W-1:0]          count_q, count_d;
  logic [MSG_WORDS*FTM_DATA_W-1:0] msg_q, msg_d;
  logic                            mvalid_q, mvalid_d;
  logic                            beat, rlast, cmp_beat, match, fire, cap_beat, cap_done;
  int                              word_sel;
  logic [FTM_DATA_W-1:0]           pat_word [NUM_PATTERNS];
  logic [FTM_DATA_W-1:0]           pat_mask [NUM_PATTERNS];

  assign beat  = rx.RvviAxiRvalid;
  assign rlast = rx.RvviAxiRlast;

  // Select each pattern's word for the current beat; past WORDS the selection is never used
  always_comb begin
    word_sel = (int'(word_idx_q) < WORDS) ? int'(word_idx_q) : 0;
    for (int p = 0; p < NUM_PATTERNS; p++) begin
      pat_word[p] = PatternString_i[(p*WORDS + word_sel)*FTM_DATA_W +: FTM_DATA_W];
      pat_mask[p] = PatternMask_i[(p*WORDS + word_sel)*FTM_DATA_W +: FTM_DATA_W];
    end
  end

  for (genvar p = 0; p < NUM_PATTERNS; p++) begin : g_cmp
    logic [FTM_STRB_W-1:0] byte_pass;
    trigger_pattern_cmp u_cmp (
      .word_i      (pat_word[p]),
      .mask_i      (pat_mask[p]),
      .strb_i      (rx.RvviAxiRstrb),
      .data_i      (rx.RvviAxiRdata),
      .byte_pass_o (byte_pass)
    );
    assign word_pass[p] = &byte_pass;
  end

  // The first beat of a frame starts from the enables; later beats narrow the surviving set
  assign alive_cur = ((state_q == FTM_IDLE) ? PatternEn_i : alive_q) & word_pass;
  assign match     = cmp_beat && (word_idx_q == IDX_W'(WORDS - 1)) && (|alive_cur);
  assign cap_done  = cap_beat && ((cap_slot == SLOT_W'(MSG_WORDS - 1)) || rlast);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= FTM_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FTM_IDLE, FTM_COMPARE: begin
        if (beat) begin
          if (match)                 state_d = FTM_TRIGGER;
          else if (rlast)            state_d = FTM_IDLE;
          else if (alive_cur == '0)  state_d = FTM_SKIP;
          else                       state_d = FTM_COMPARE;
        end
      end
      FTM_TRIGGER: begin
        if (last_q)        state_d = FTM_IDLE;
        else if (cap_done) state_d = rlast ? FTM_IDLE : FTM_SKIP;
        else               state_d = FTM_CAPTURE;
      end
      FTM_CAPTURE: if (cap_done) state_d = rlast ? FTM_IDLE : FTM_SKIP;
      FTM_SKIP:    if (beat && rlast) state_d = FTM_IDLE;
      default:     state_d = FTM_IDLE;
    endcase
  end

  // FSM outputs: the beat following a match lands in message slot 0 during the TRIGGER cycle
  always_comb begin
    cmp_beat = 1'b0;
    fire     = 1'b0;
    cap_beat = 1'b0;
    cap_slot = slot_q;
    case (state_q)
      FTM_IDLE, FTM_COMPARE: cmp_beat = beat;
      FTM_TRIGGER: begin
        fire     = 1'b1;
        cap_beat = beat && !last_q;
        cap_slot = '0;
      end
      FTM_CAPTURE: cap_beat = beat;
      default: ;
    endcase
  end

  // Datapath next state: word index, alive set, latched trigger results, pulse timer, message slots
  always_comb begin
    word_idx_d = word_idx_q;
    alive_d    = alive_q;
    last_d     = last_q;
    id_d       = id_q;
    count_d    = count_q;
    msg_d      = msg_q;
    slot_d     = slot_q;
    pulse_d    = (pulse_q != '0) ? pulse_q - 1'b1 : pulse_q;
    mvalid_d   = cap_done || (fire && last_q);
    if (beat) begin
      if (rlast)                            word_idx_d = '0;
      else if (word_idx_q != IDX_W'(WORDS)) word_idx_d = word_idx_q + 1'b1;
    end
    if (cmp_beat) alive_d = alive_cur;
    if (match)    last_d  = rlast;
    if (fire) begin
      pulse_d = PC_W'(TRIG_CYCLES);
      count_d = sat_inc(count_q);
      msg_d   = '0;
      slot_d  = '0;
      for (int p = NUM_PATTERNS - 1; p >= 0; p--) begin
        if (alive_q[p]) id_d = ID_W'(p);
      end
    end
    if (cap_beat) begin
      msg_d[int'(cap_slot)*FTM_DATA_W +: FTM_DATA_W] = rx.RvviAxiRdata;
      slot_d = cap_slot + 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      word_idx_q <= '0;
      alive_q    <= '0;
      last_q     <= 1'b0;
      id_q       <= '0;
      count_q    <= '0;
      msg_q      <= '0;
      slot_q     <= '0;
      pulse_q    <= '0;
      mvalid_q   <= 1'b0;
    end else begin
      word_idx_q <= word_idx_d;
      alive_q    <= alive_d;
      last_q     <= last_d;
      id_q       <= id_d;
      count_q    <= count_d;
      msg_q      <= msg_d;
      slot_q     <= slot_d;
      pulse_q    <= pulse_d;
      mvalid_q   <= mvalid_d;
    end
  end

  assign IlaTrigger_o     = (pulse_q != '0);
  assign TriggerId_o      = id_q;
  assign TriggerMessage_o = msg_q;
  assign MessageValid_o   = mvalid_q;
  assign TriggerCount_o   = count_q;

endmodule

// File: tb/tb_frame_trigger_matcher.sv
// tb/tb_frame_trigger_matcher.sv - table-driven bench for frame_trigger_matcher
module tb_frame_trigger_matcher;
  import frame_trigger_matcher_pkg::*;

  localparam int WORDS = 5;
  localparam int NP    = 2;
  localparam int TRIG  = 10;
  localparam int MSGW  = 1;
  localparam int ID_W  = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frame_trigger_matcher_if rx ();

  logic [NP*WORDS*32-1:0] pat_s, pat_m;
  logic [NP-1:0]          pat_en;
  logic                   ila, mvalid;
  logic [ID_W-1:0]        tid;
  logic [MSGW*32-1:0]     tmsg;
  logic [15:0]            tcnt;

  frame_trigger_matcher #(
    .WORDS(WORDS), .NUM_PATTERNS(NP), .TRIG_CYCLES(TRIG), .MSG_WORDS(MSGW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .rx               (rx),
    .PatternString_i  (pat_s),
    .PatternMask_i    (pat_m),
    .PatternEn_i      (pat_en),
    .IlaTrigger_o     (ila),
    .TriggerId_o      (tid),
    .TriggerMessage_o (tmsg),
    .MessageValid_o   (mvalid),
    .TriggerCount_o   (tcnt)
  );

  typedef struct {
    logic [1:0]      en;
    logic            same;
    logic            src1;
    logic            m3lo;
    logic            m4b3;
    int              xw;
    logic [31:0]     xv;
    logic [3:0]      strb4;
    int              nb;
    logic            trig;
    logic [ID_W-1:0] id;
    logic [31:0]     msg;
  } vec_t;

  vec_t vecs [15];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] s, input logic l);
    rx.RvviAxiRvalid = v;
    rx.RvviAxiRdata  = d;
    rx.RvviAxiRstrb  = s;
    rx.RvviAxiRlast  = l;
  endtask

  function automatic logic [31:0] p0w(input int w);
    return 32'hA5A50000 + 32'(w) * 32'h0101;
  endfunction

  function automatic logic [31:0] p1w(input int w);
    return 32'h5A5A0000 + 32'(w) * 32'h0101;
  endfunction

  task automatic configure(input logic [1:0] en, input logic same, input logic m3lo, input logic m4b3);
    pat_en = en;
    pat_m  = '1;
    for (int w = 0; w < WORDS; w++) begin
      pat_s[w*32 +: 32]         = p0w(w);
      pat_s[(WORDS+w)*32 +: 32] = same ? p0w(w) : p1w(w);
    end
    if (m3lo) begin
      pat_m[3*32 +: 16]         = '0;
      pat_m[(WORDS+3)*32 +: 16] = '0;
    end
    if (m4b3) begin
      pat_m[4*32+24 +: 8]         = '0;
      pat_m[(WORDS+4)*32+24 +: 8] = '0;
    end
  endtask

  function automatic logic [31:0] fbeat(input int b, input logic src1, input int xw, input logic [31:0] xv);
    logic [31:0] d;
    if (b < WORDS) begin
      d = pat_s[((src1 ? WORDS : 0) + b)*32 +: 32];
      if (b == xw) d = d ^ xv;
    end else begin
      d = 32'hC0DE0000 | 32'(b);
    end
    return d;
  endfunction

  task automatic run_frame(input int nb, input logic src1, input int xw, input logic [31:0] xv,
                           input logic [3:0] strb4, output int rise, output int hi, output int mvc,
                           output logic [31:0] msg, output logic [ID_W-1:0] id);
    rise = -1; hi = 0; mvc = 0; msg = '0; id = '0;
    for (int c = 0; c < 32; c++) begin
      if (c < nb) drive(1'b1, fbeat(c, src1, xw, xv), (c == WORDS-1) ? strb4 : 4'hF, c == nb-1);
      else        drive(1'b0, 32'h0, 4'h0, 1'b0);
      tick();
      if (ila) begin
        if (rise < 0) begin rise = c + 1; id = tid; end
        hi++;
      end
      if (mvalid) begin mvc++; msg = tmsg; end
    end
  endtask

  initial begin
    int              rise, hi, mvc, first, last;
    logic [31:0]     msg;
    logic [ID_W-1:0] id;
    int              exp_cnt;
    logic [ID_W-1:0] exp_id;

    //         en     same  src1  m3lo  m4b3  xw  xv            strb4 nb trig  id    msg
    vecs[0]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32'h0,        4'hF, 8, 1'b1, 1'b0, 32'hC0DE0005};
    vecs[1]  = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b0, -1, 32'h0,        4'hF, 8, 1'b1, 1'b1, 32'hC0DE0005};
    vecs[2]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, -1, 32'h0,        4'hF, 8, 1'b1, 1'b0, 32'hC0DE0005};
    vecs[3]  = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b0,  3, 32'h0000BEEF, 4'hF, 8, 1'b1, 1'b0, 32'hC0DE0005};
    vecs[4]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0,  3, 32'h80000000, 4'hF, 8, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32'h0,        4'hF, 8, 1'b1, 1'b0, 32'hC0DE0005};
    vecs[6]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32'h0,        4'hF, 3, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32'h0,        4'hF, 5, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32'h0,        4'h7, 8, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b1, -1, 32'h0,        4'h7, 8, 1'b1, 1'b0, 32'hC0DE0005};
    vecs[10] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32'h0,        4'hF, 8, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, -1, 32'h0,        4'hF, 8, 1'b1, 1'b1, 32'hC0DE0005};
    vecs[12] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0,  4, 32'h00000001, 4'hF, 8, 1'b0, 1'b0, 32'h0};
    vecs[13] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0,  0, 32'h00000001, 4'hF, 8, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, -1, 32'h0,        4'hF, 6, 1'b1, 1'b0, 32'hC0DE0005};

    reset = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 1'b0);
    configure(2'b01, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check("reset ila",   32'(ila),    32'h0);
    check("reset id",    32'(tid),    32'h0);
    check("reset msg",   32'(tmsg),   32'h0);
    check("reset mv",    32'(mvalid), 32'h0);
    check("reset count", 32'(tcnt),   32'h0);
    reset = 1'b1;

    exp_cnt = 0;
    exp_id  = '0;
    for (int i = 0; i < 15; i++) begin
      configure(vecs[i].en, vecs[i].same, vecs[i].m3lo, vecs[i].m4b3);
      run_frame(vecs[i].nb, vecs[i].src1, vecs[i].xw, vecs[i].xv, vecs[i].strb4, rise, hi, mvc, msg, id);
      if (vecs[i].trig) begin
        exp_cnt++;
        exp_id = vecs[i].id;
      end
      check($sformatf("v%0d rise", i), rise, vecs[i].trig ? 32'd6 : 32'hFFFFFFFF);
      check($sformatf("v%0d high", i), hi, vecs[i].trig ? TRIG : 0);
      check($sformatf("v%0d mvcnt", i), mvc, vecs[i].trig ? 32'd1 : 32'd0);
      if (vecs[i].trig) begin
        check($sformatf("v%0d id", i), 32'(id), 32'(vecs[i].id));
        check($sformatf("v%0d msg", i), msg, vecs[i].msg);
      end
      check($sformatf("v%0d count", i), 32'(tcnt), exp_cnt);
      check($sformatf("v%0d held id", i), 32'(tid), 32'(exp_id));
    end

    // Retrigger: second frame matches while the first pulse is still high
    configure(2'b01, 1'b0, 1'b0, 1'b0);
    first = -1; last = -1; hi = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 5)                drive(1'b1, fbeat(c, 1'b0, -1, 32'h0), 4'hF, c == 4);
      else if (c >= 6 && c < 11) drive(1'b1, fbeat(c-6, 1'b0, -1, 32'h0), 4'hF, c == 10);
      else                      drive(1'b0, 32'h0, 4'h0, 1'b0);
      tick();
      if (ila) begin
        if (first < 0) first = c + 1;
        last = c + 1;
        hi++;
      end
    end
    exp_cnt += 2;
    check("retrig first", first, 32'd6);
    check("retrig last",  last,  32'd21);
    check("retrig high",  hi,    32'd16);
    check("retrig count", 32'(tcnt), exp_cnt);

    // Reset mid-pulse after a pattern-1 trigger with a captured message
    configure(2'b11, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      if (c < 6) drive(1'b1, fbeat(c, 1'b1, -1, 32'h0), 4'hF, c == 5);
      else       drive(1'b0, 32'h0, 4'h0, 1'b0);
      if (c == 8) reset = 1'b0;
      tick();
      if (c == 7) begin
        check("pre-reset ila", 32'(ila),  32'h1);
        check("pre-reset id",  32'(tid),  32'h1);
        check("pre-reset msg", 32'(tmsg), 32'hC0DE0005);
      end
      if (c == 8) begin
        check("mid-reset ila",   32'(ila),    32'h0);
        check("mid-reset id",    32'(tid),    32'h0);
        check("mid-reset msg",   32'(tmsg),   32'h0);
        check("mid-reset mv",    32'(mvalid), 32'h0);
        check("mid-reset count", 32'(tcnt),   32'h0);
        reset = 1'b1;
      end
    end
    configure(2'b01, 1'b0, 1'b0, 1'b0);
    run_frame(8, 1'b0, -1, 32'h0, 4'hF, rise, hi, mvc, msg, id);
    check("post-reset rise",  rise, 32'd6);
    check("post-reset count", 32'(tcnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
